// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, line-ending constants and sizing helper for the
// UART byte-stream blocks.
package uart_pkg;

  typedef enum logic {
    BANNER = 1'b0,
    ECHO   = 1'b1
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Occupancy counter needs one extra bit to represent "full".
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-high reset; pop when full
// frees the slot so a simultaneous push is accepted.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   push,
  input  logic [DATA_WIDTH-1:0]                  push_data,
  input  logic                                   pop,
  output logic [DATA_WIDTH-1:0]                  pop_data,
  output logic                                   full,
  output logic                                   empty,
  output logic [fifo_count_width(FIFO_DEPTH)-1:0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = fifo_count_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // NOTE: storage has no reset; count/pointers gate every read, so stale
  // contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_banner_echo.sv
// uart_banner_echo: sends a banner after reset (or on TRIGGER_CHAR), then echoes
// rx bytes through a FIFO. Define BANNER_CRLF_EN to append CR LF to the banner.
module uart_banner_echo
  import uart_pkg::*;
#(
  parameter int                          DATA_WIDTH   = 8,
  parameter int                          MSG_LEN      = 16,
  parameter logic [DATA_WIDTH*MSG_LEN-1:0] MSG        = "Hello, World!   ",
  parameter int                          FIFO_DEPTH   = 16,
  parameter logic [DATA_WIDTH-1:0]       TRIGGER_CHAR = 8'h12
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_WIDTH-1:0]                  rx_data,
  input  logic                                   rx_valid,
  input  logic                                   tx_ready,
  output logic [DATA_WIDTH-1:0]                  tx_data,
  output logic                                   tx_valid,
  output logic                                   banner_busy,
  output logic                                   overflow,
  output logic [fifo_count_width(FIFO_DEPTH)-1:0] fifo_count
);

`ifdef BANNER_CRLF_EN
  localparam int BANNER_LEN = MSG_LEN + 2;
`else
  localparam int BANNER_LEN = MSG_LEN;
`endif
  localparam int IDX_W    = (BANNER_LEN > 1) ? $clog2(BANNER_LEN) : 1;
  localparam int ROM_SIZE = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BANNER_LEN - 1);

  // Character 0 is the most significant word of MSG (string-literal order).
  logic [DATA_WIDTH-1:0] banner_rom [ROM_SIZE];
  for (genvar i = 0; i < ROM_SIZE; i++) begin : g_rom
    if (i < MSG_LEN) begin : g_msg
      assign banner_rom[i] = MSG[DATA_WIDTH*(MSG_LEN-1-i) +: DATA_WIDTH];
`ifdef BANNER_CRLF_EN
    end else if (i == MSG_LEN) begin : g_cr
      assign banner_rom[i] = DATA_WIDTH'(CR);
    end else if (i == MSG_LEN + 1) begin : g_lf
      assign banner_rom[i] = DATA_WIDTH'(LF);
`endif
    end else begin : g_pad
      assign banner_rom[i] = '0;
    end
  end

  state_t                state, state_d;
  logic [IDX_W-1:0]      index, index_d;
  logic                  banner_pending, pending_d;
  logic                  tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_d;
  logic                  overflow_d;
  logic                  load_en;
  logic                  rx_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign rx_push     = rx_valid && (rx_data != TRIGGER_CHAR);
  // Output register is free when empty or being consumed this cycle.
  assign load_en     = !tx_valid || tx_ready;
  assign banner_busy = (state == BANNER);

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_push),
    .push_data(rx_data),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state;
    index_d    = index;
    pending_d  = banner_pending;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    fifo_pop   = 1'b0;

    if (rx_valid && (rx_data == TRIGGER_CHAR) && (state == ECHO)) pending_d = 1'b1;

    if (load_en) begin
      unique case (state)
        BANNER: begin
          tx_valid_d = 1'b1;
          tx_data_d  = banner_rom[index];
          if (index == LAST_IDX) begin
            state_d = ECHO;
            index_d = '0;
          end else begin
            index_d = index + IDX_W'(1);
          end
        end
        ECHO: begin
          if (banner_pending) begin
            state_d    = BANNER;
            pending_d  = 1'b0;
            tx_valid_d = 1'b0;
          end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = fifo_head;
          end else begin
            tx_valid_d = 1'b0;
          end
        end
      endcase
    end

    overflow_d = overflow || (rx_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BANNER;
      index          <= '0;
      banner_pending <= 1'b0;
      tx_valid       <= 1'b0;
      tx_data        <= '0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_d;
      index          <= index_d;
      banner_pending <= pending_d;
      tx_valid       <= tx_valid_d;
      tx_data        <= tx_data_d;
      overflow       <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_banner_echo.sv
// tb_uart_banner_echo: scoreboard bench for uart_banner_echo with a short
// "Hi!" banner and a 4-entry FIFO; honours BANNER_CRLF_EN.
module tb_uart_banner_echo;

  localparam int DW = 8;
  localparam int ML = 3;
  localparam int FD = 4;
  localparam int CW = $clog2(FD) + 1;
  localparam logic [DW-1:0] TRIG = 8'h12;
`ifdef BANNER_CRLF_EN
  localparam int BL = ML + 2;
`else
  localparam int BL = ML;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          banner_busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  logic [DW-1:0] banner_exp [BL];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;
  logic          held = 1'b0;
  logic [DW-1:0] held_data = '0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_tx = 0;

  uart_banner_echo #(
    .DATA_WIDTH  (DW),
    .MSG_LEN     (ML),
    .MSG         ("Hi!"),
    .FIFO_DEPTH  (FD),
    .TRIGGER_CHAR(TRIG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .banner_busy(banner_busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Monitor at negedge: a valid&&ready seen here is the transfer at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== held_data) begin
          n_err++;
          $display("FAIL tx_hold: tx_valid=%b tx_data=%h, required 1 and %h", tx_valid, tx_data, held_data);
        end
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        n_cmp++;
        n_tx++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_unexpected: got %h, required no transfer", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_data !== mon_exp) begin
            n_err++;
            $display("FAIL tx_byte: got %h, required %h", tx_data, mon_exp);
          end
        end
      end
      held      = (tx_valid === 1'b1) && !tx_ready;
      held_data = tx_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_banner();
    for (int i = 0; i < BL; i++) exp_q.push_back(banner_exp[i]);
  endtask

  task automatic drive_rx(input logic [DW-1:0] b, input bit expect_echo);
    rx_data  = b;
    rx_valid = 1'b1;
    if (expect_echo) exp_q.push_back(b);
    step();
  endtask

  task automatic wait_drain();
    int c = 0;
    tx_ready = 1'b1;
    while ((exp_q.size() != 0 || tx_valid !== 1'b0) && c < 200) begin
      step();
      c++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || tx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain: %0d bytes outstanding, tx_valid=%b, required 0 and 0", exp_q.size(), tx_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    step();
    step();
    n_cmp++; if (tx_valid !== 1'b0)    begin n_err++; $display("FAIL rst_tx_valid: got %b, required 0", tx_valid); end
    n_cmp++; if (tx_data !== '0)       begin n_err++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
    n_cmp++; if (banner_busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b, required 1", banner_busy); end
    n_cmp++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    n_cmp++; if (fifo_count !== '0)    begin n_err++; $display("FAIL rst_count: got %0d, required 0", fifo_count); end
  endtask

  task automatic test_banner();
    push_banner();
    tx_ready = 1'b1;
    rst = 1'b0;
    step();
    for (int k = 0; k < BL; k++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || banner_busy !== (k != BL - 1)) begin
        n_err++;
        $display("FAIL banner_stream[%0d]: tx_valid=%b busy=%b, required 1 and %b", k, tx_valid, banner_busy, k != BL - 1);
      end
      step();
    end
    n_cmp++;
    if (tx_valid !== 1'b0 || banner_busy !== 1'b0) begin
      n_err++;
      $display("FAIL banner_end: tx_valid=%b busy=%b, required 0 and 0", tx_valid, banner_busy);
    end
  endtask

  task automatic test_echo();
    tx_ready = 1'b1;
    drive_rx(8'h41, 1'b1);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL echo_lat1: tx_valid=%b, required 0", tx_valid); end
    drive_rx(8'h42, 1'b1);
    rx_valid = 1'b0;
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      n_err++;
      $display("FAIL echo_lat2: tx_valid=%b tx_data=%h, required 1 and 41", tx_valid, tx_data);
    end
    wait_drain();
  endtask

  task automatic test_trigger();
    tx_ready = 1'b1;
    drive_rx(8'h31, 1'b1);
    push_banner();
    drive_rx(TRIG, 1'b0);
    drive_rx(8'h32, 1'b1);
    rx_valid = 1'b0;
    n_cmp++; if (banner_busy !== 1'b1) begin n_err++; $display("FAIL trig_busy: got %b, required 1", banner_busy); end
    wait_drain();
  endtask

  task automatic test_full_push_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_rx(DW'(8'hA0 + i), 1'b1);
    n_cmp++; if (fifo_count !== CW'(4)) begin n_err++; $display("FAIL fpp_fill: count=%0d, required 4", fifo_count); end
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    exp_q.push_back(8'hA5);
    tx_ready = 1'b1;
    step();
    rx_valid = 1'b0;
    n_cmp++; if (fifo_count !== CW'(4)) begin n_err++; $display("FAIL fpp_count: count=%0d, required 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b0)     begin n_err++; $display("FAIL fpp_overflow: got %b, required 0", overflow); end
    wait_drain();
    n_cmp++; if (fifo_count !== '0)     begin n_err++; $display("FAIL fpp_empty: count=%0d, required 0", fifo_count); end
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_rx(DW'(8'hB0 + i), 1'b1);
    drive_rx(8'hB5, 1'b0);
    rx_valid = 1'b0;
    n_cmp++; if (fifo_count !== CW'(4)) begin n_err++; $display("FAIL ovf_count: count=%0d, required 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b1)     begin n_err++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    step();
    wait_drain();
    n_cmp++; if (overflow !== 1'b1)     begin n_err++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    n_cmp++; if (fifo_count !== '0)     begin n_err++; $display("FAIL ovf_empty: count=%0d, required 0", fifo_count); end
  endtask

  task automatic test_stall();
    int c = 0;
    rst = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    step();
    exp_q.delete();
    push_banner();
    rst = 1'b0;
    while (exp_q.size() != 0 && c < 100) begin
      tx_ready = (c % 4 == 0) || (c % 4 == 3);
      if (c == 1) begin
        n_cmp++;
        if (banner_busy !== 1'b1) begin n_err++; $display("FAIL stall_busy: got %b, required 1", banner_busy); end
        rx_data  = TRIG;
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
      step();
      c++;
    end
    rx_valid = 1'b0;
    wait_drain();
    repeat (10) step();
    n_cmp++;
    if (tx_valid !== 1'b0 || banner_busy !== 1'b0) begin
      n_err++;
      $display("FAIL trig_in_banner: tx_valid=%b busy=%b, required 0 and 0", tx_valid, banner_busy);
    end
  endtask

  task automatic test_rst_mid();
    int base;
    int c = 0;
    rst = 1'b1;
    tx_ready = 1'b1;
    step();
    exp_q.delete();
    push_banner();
    base = n_tx;
    rst = 1'b0;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    exp_q.push_back(8'h55);
    step();
    rx_valid = 1'b0;
    while (n_tx < base + 2 && c < 50) begin
      step();
      c++;
    end
    n_cmp++; if (n_tx != base + 2)       begin n_err++; $display("FAIL mid_accepted: got %0d, required 2", n_tx - base); end
    n_cmp++; if (fifo_count !== CW'(1))  begin n_err++; $display("FAIL mid_count: count=%0d, required 1", fifo_count); end
    rst = 1'b1;
    step();
    n_cmp++; if (tx_valid !== 1'b0)      begin n_err++; $display("FAIL mid_tx_valid: got %b, required 0", tx_valid); end
    n_cmp++; if (fifo_count !== '0)      begin n_err++; $display("FAIL mid_fifo: count=%0d, required 0", fifo_count); end
    n_cmp++; if (banner_busy !== 1'b1)   begin n_err++; $display("FAIL mid_busy: got %b, required 1", banner_busy); end
    n_cmp++; if (overflow !== 1'b0)      begin n_err++; $display("FAIL mid_overflow: got %b, required 0", overflow); end
    n_cmp++; if (exp_q.size() != BL - 1) begin n_err++; $display("FAIL mid_pending: got %0d, required %0d", exp_q.size(), BL - 1); end
    exp_q.delete();
    push_banner();
    rst = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    banner_exp[0] = 8'h48;
    banner_exp[1] = 8'h69;
    banner_exp[2] = 8'h21;
`ifdef BANNER_CRLF_EN
    banner_exp[3] = 8'h0D;
    banner_exp[4] = 8'h0A;
`endif
    test_reset();
    test_banner();
    test_echo();
    test_trigger();
    test_full_push_pop();
    test_overflow();
    test_stall();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
